csr_unit_v2: RTL and testbench

- Parametrised second-generation control/status register file for the LoongArch pipeline, instantiated beside the writeback stage.
- Holds CRMD, PRMD, ECFG, ESTAT, ERA, BADV, EENTRY, SAVE0..SAVE_N-1, TID, TCFG, TVAL and TICLR.
- Performs exception entry and ERTN state swaps and generates a qualified interrupt request.
- Adds over the previous generation: configurable timer width, configurable SAVE count, synchronised hardware interrupt lines, IPI, and a sticky timer interrupt with explicit clear.

---
 rtl/csr_pkg.sv | 44 ++++
 rtl/csr_unit_v2_if.sv | 20 ++
 rtl/csr_timer.sv | 65 ++++++
 rtl/csr_unit_v2.sv | 197 +++++++++++++++++++
 tb/tb_csr_unit_v2.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, exception codes and field bit positions shared by
// the csr_unit_v2 register file, its timer and its users.
package csr_pkg;

    typedef logic [13:0] csr_addr_t;

    // CSR addresses
    localparam csr_addr_t CSR_CRMD   = 14'h000;
    localparam csr_addr_t CSR_PRMD   = 14'h001;
    localparam csr_addr_t CSR_ECFG   = 14'h004;
    localparam csr_addr_t CSR_ESTAT  = 14'h005;
    localparam csr_addr_t CSR_ERA    = 14'h006;
    localparam csr_addr_t CSR_BADV   = 14'h007;
    localparam csr_addr_t CSR_EENTRY = 14'h00C;
    localparam csr_addr_t CSR_SAVE   = 14'h030;
    localparam csr_addr_t CSR_TID    = 14'h040;
    localparam csr_addr_t CSR_TCFG   = 14'h041;
    localparam csr_addr_t CSR_TVAL   = 14'h042;
    localparam csr_addr_t CSR_TICLR  = 14'h044;

    // Exception codes
    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;

    // Field bit positions
    localparam int unsigned CRMD_W          = 9;
    localparam int unsigned CRMD_IE         = 2;
    localparam int unsigned PRMD_W          = 3;
    localparam int unsigned PRMD_PIE        = 2;
    localparam int unsigned ECFG_LIE_W      = 13;
    localparam int unsigned ECFG_LIE_RSVD   = 10;
    localparam int unsigned ESTAT_IS_W      = 13;
    localparam int unsigned ESTAT_IS_TI     = 11;
    localparam int unsigned ESTAT_IS_IPI    = 12;
    localparam int unsigned ESTAT_ECODE_LO  = 16;
    localparam int unsigned TCFG_EN         = 0;
    localparam int unsigned TCFG_PERIODIC   = 1;
    localparam int unsigned TCFG_INITVAL_LO = 2;

endpackage

// File: rtl/csr_unit_v2_if.sv
// csr_unit_v2_if: CSR read/write access bus between the pipeline (master)
// and the register file (slave).
interface csr_unit_v2_if;
    logic [13:0] csr_raddr;
    logic [31:0] csr_rdata;
    logic        csr_we;
    logic [13:0] csr_waddr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_wmask;

    modport master (
        output csr_raddr, csr_we, csr_waddr, csr_wdata, csr_wmask,
        input  csr_rdata
    );

    modport slave (
        input  csr_raddr, csr_we, csr_waddr, csr_wdata, csr_wmask,
        output csr_rdata
    );
endinterface

// File: rtl/csr_timer.sv
// csr_timer: TCFG/TVAL countdown timer with a sticky timer interrupt (TI).
// TI is set on a 1->0 decrement and cleared by TICLR; set wins over clear.
module csr_timer
    import csr_pkg::*;
#(
    parameter int unsigned TIMER_W = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wdata,
    input  logic [TIMER_W-1:0] tcfg_wmask,
    input  logic               ticlr,
    output logic [TIMER_W-1:0] tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               ti
);

    logic [TIMER_W-1:0] tcfg_q, tcfg_d;
    logic [TIMER_W-1:0] tval_q, tval_d;
    logic               ti_q, ti_d;
    logic               expire;

    // Next-state: config write/reload, countdown, periodic reload, TI set/clear
    always_comb begin
        tcfg_d = tcfg_q;
        tval_d = tval_q;
        expire = 1'b0;
        if (tcfg_we) begin
            tcfg_d = (tcfg_q & ~tcfg_wmask) | (tcfg_wdata & tcfg_wmask);
            if (tcfg_d[TCFG_EN]) begin
                tval_d = {tcfg_d[TIMER_W-1:TCFG_INITVAL_LO], 2'b00};
            end
        end else if (tcfg_q[TCFG_EN]) begin
            if (tval_q != '0) begin
                tval_d = tval_q - TIMER_W'(1);
                expire = (tval_q == TIMER_W'(1));
            end else if (tcfg_q[TCFG_PERIODIC]) begin
                // InitVal=0 reloads 0, so the timer idles without firing
                tval_d = {tcfg_q[TIMER_W-1:TCFG_INITVAL_LO], 2'b00};
            end
        end
        ti_d = ti_q;
        if (ticlr)  ti_d = 1'b0;
        if (expire) ti_d = 1'b1;
    end

    // Timer state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tcfg_q <= '0;
            tval_q <= '0;
            ti_q   <= 1'b0;
        end else begin
            tcfg_q <= tcfg_d;
            tval_q <= tval_d;
            ti_q   <= ti_d;
        end
    end

    assign tcfg = tcfg_q;
    assign tval = tval_q;
    assign ti   = ti_q;

endmodule

// File: rtl/csr_unit_v2.sv
// csr_unit_v2: LoongArch CSR file with exception entry/ERTN swaps, timer,
// synchronised hardware/IPI interrupt lines and a qualified interrupt request.
// Optional free-running 64-bit stable counter when CSR_STABLE_CNT_EN is defined.
module csr_unit_v2
    import csr_pkg::*;
#(
    parameter int unsigned TIMER_W     = 32,
    parameter int unsigned SAVE_N      = 4,
    parameter int unsigned HWI_N       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    csr_unit_v2_if.slave      csr_bus,
    input  logic              exc_valid,
    input  logic [5:0]        exc_ecode,
    input  logic [8:0]        exc_esubcode,
    input  logic [31:0]       exc_pc,
    input  logic              exc_badv_we,
    input  logic [31:0]       exc_badv,
    input  logic              ertn,
    input  logic [HWI_N-1:0]  hw_int,
    input  logic              ipi_int,
    output logic [31:0]       era,
    output logic [31:0]       eentry,
    output logic              int_pending
`ifdef CSR_STABLE_CNT_EN
    ,
    output logic [63:0]       stable_cnt
`endif
);

    logic [CRMD_W-1:0]      crmd_q, crmd_d;
    logic [PRMD_W-1:0]      prmd_q, prmd_d;
    logic [ECFG_LIE_W-1:0]  lie_q, lie_d;
    logic [1:0]             swi_q, swi_d;
    logic [14:0]            estat_exc_q, estat_exc_d;   // {EsubCode, Ecode}
    logic [31:0]            era_q, era_d, badv_q, badv_d, tid_q, tid_d;
    logic [25:0]            eentry_q, eentry_d;
    logic [SAVE_N-1:0][31:0] save_q, save_d;
    logic [SYNC_STAGES-1:0][HWI_N:0] sync_q;
    logic [ESTAT_IS_W-1:0]  is_vec;
    logic [TIMER_W-1:0]     tcfg, tval;
    logic                   ti;
    logic [31:0]            wd, wm;
    logic                   tcfg_we, ticlr;

    assign wd = csr_bus.csr_wdata;
    assign wm = csr_bus.csr_wmask;
    assign tcfg_we = csr_bus.csr_we && (csr_bus.csr_waddr == CSR_TCFG);
    assign ticlr   = csr_bus.csr_we && (csr_bus.csr_waddr == CSR_TICLR) && wd[0] && wm[0];

    csr_timer #(.TIMER_W(TIMER_W)) u_timer (
        .clk        (clk),
        .resetn     (resetn),
        .tcfg_we    (tcfg_we),
        .tcfg_wdata (wd[TIMER_W-1:0]),
        .tcfg_wmask (wm[TIMER_W-1:0]),
        .ticlr      (ticlr),
        .tcfg       (tcfg),
        .tval       (tval),
        .ti         (ti)
    );

    // Next-state: masked CSR writes, then ERTN, then exception override
    always_comb begin
        crmd_d      = crmd_q;
        prmd_d      = prmd_q;
        lie_d       = lie_q;
        swi_d       = swi_q;
        estat_exc_d = estat_exc_q;
        era_d       = era_q;
        badv_d      = badv_q;
        eentry_d    = eentry_q;
        tid_d       = tid_q;
        save_d      = save_q;
        if (csr_bus.csr_we) begin
            unique case (csr_bus.csr_waddr)
                CSR_CRMD:   crmd_d   = (crmd_q & ~wm[8:0]) | (wd[8:0] & wm[8:0]);
                CSR_PRMD:   prmd_d   = (prmd_q & ~wm[2:0]) | (wd[2:0] & wm[2:0]);
                CSR_ECFG:   lie_d    = (lie_q & ~wm[12:0]) | (wd[12:0] & wm[12:0]);
                CSR_ESTAT:  swi_d    = (swi_q & ~wm[1:0]) | (wd[1:0] & wm[1:0]);
                CSR_ERA:    era_d    = (era_q & ~wm) | (wd & wm);
                CSR_BADV:   badv_d   = (badv_q & ~wm) | (wd & wm);
                CSR_EENTRY: eentry_d = (eentry_q & ~wm[31:6]) | (wd[31:6] & wm[31:6]);
                CSR_TID:    tid_d    = (tid_q & ~wm) | (wd & wm);
                default: begin
                    for (int unsigned i = 0; i < SAVE_N; i++) begin
                        if (csr_bus.csr_waddr == CSR_SAVE + 14'(i)) begin
                            save_d[i] = (save_q[i] & ~wm) | (wd & wm);
                        end
                    end
                end
            endcase
        end
        lie_d[ECFG_LIE_RSVD] = 1'b0;
        if (ertn) begin
            crmd_d[2:0] = prmd_q;
        end
        if (exc_valid) begin
            prmd_d      = crmd_q[2:0];
            crmd_d[2:0] = 3'b000;
            era_d       = exc_pc;
            estat_exc_d = {exc_esubcode, exc_ecode};
            if (exc_badv_we) badv_d = exc_badv;
        end
    end

    // Architectural register state
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            crmd_q      <= 9'h008;
            prmd_q      <= '0;
            lie_q       <= '0;
            swi_q       <= '0;
            estat_exc_q <= '0;
            era_q       <= '0;
            badv_q      <= '0;
            eentry_q    <= '0;
            tid_q       <= '0;
            save_q      <= '0;
        end else begin
            crmd_q      <= crmd_d;
            prmd_q      <= prmd_d;
            lie_q       <= lie_d;
            swi_q       <= swi_d;
            estat_exc_q <= estat_exc_d;
            era_q       <= era_d;
            badv_q      <= badv_d;
            eentry_q    <= eentry_d;
            tid_q       <= tid_d;
            save_q      <= save_d;
        end
    end

    // Synchroniser chain for {ipi_int, hw_int}
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {ipi_int, hw_int}};
        end
    end

    // Assemble ESTAT.IS from software, hardware, timer and IPI sources
    always_comb begin
        is_vec               = '0;
        is_vec[1:0]          = swi_q;
        is_vec[2 +: HWI_N]   = sync_q[SYNC_STAGES-1][HWI_N-1:0];
        is_vec[ESTAT_IS_TI]  = ti;
        is_vec[ESTAT_IS_IPI] = sync_q[SYNC_STAGES-1][HWI_N];
    end

    // Combinational read mux; unimplemented addresses read 0
    always_comb begin
        csr_bus.csr_rdata = '0;
        case (csr_bus.csr_raddr)
            CSR_CRMD:   csr_bus.csr_rdata = 32'(crmd_q);
            CSR_PRMD:   csr_bus.csr_rdata = 32'(prmd_q);
            CSR_ECFG:   csr_bus.csr_rdata = 32'(lie_q);
            CSR_ESTAT:  csr_bus.csr_rdata = {1'b0, estat_exc_q, 3'b000, is_vec};
            CSR_ERA:    csr_bus.csr_rdata = era_q;
            CSR_BADV:   csr_bus.csr_rdata = badv_q;
            CSR_EENTRY: csr_bus.csr_rdata = {eentry_q, 6'b0};
            CSR_TID:    csr_bus.csr_rdata = tid_q;
            CSR_TCFG:   csr_bus.csr_rdata = 32'(tcfg);
            CSR_TVAL:   csr_bus.csr_rdata = 32'(tval);
            default: begin
                for (int unsigned i = 0; i < SAVE_N; i++) begin
                    if (csr_bus.csr_raddr == CSR_SAVE + 14'(i)) begin
                        csr_bus.csr_rdata = save_q[i];
                    end
                end
            end
        endcase
    end

    assign era         = era_q;
    assign eentry      = {eentry_q, 6'b0};
    assign int_pending = crmd_q[CRMD_IE] & |(is_vec & lie_q);

`ifdef CSR_STABLE_CNT_EN
    logic [63:0] stable_cnt_q;

    // Free-running stable counter, wraps naturally
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stable_cnt_q <= '0;
        end else begin
            stable_cnt_q <= stable_cnt_q + 64'd1;
        end
    end

    assign stable_cnt = stable_cnt_q;
`endif

endmodule

// File: tb/tb_csr_unit_v2.sv
// tb_csr_unit_v2: directed self-checking bench for csr_unit_v2.
module tb_csr_unit_v2;
    import csr_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        exc_valid, exc_badv_we, ertn, ipi_int;
    logic [5:0]  exc_ecode;
    logic [8:0]  exc_esubcode;
    logic [31:0] exc_pc, exc_badv, era, eentry;
    logic [7:0]  hw_int;
    logic        int_pending;
`ifdef CSR_STABLE_CNT_EN
    logic [63:0] stable_cnt;
`endif

    int checks = 0;
    int failures = 0;

    csr_unit_v2_if bus ();

    csr_unit_v2 #(
        .TIMER_W     (32),
        .SAVE_N      (4),
        .HWI_N       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .csr_bus      (bus),
        .exc_valid    (exc_valid),
        .exc_ecode    (exc_ecode),
        .exc_esubcode (exc_esubcode),
        .exc_pc       (exc_pc),
        .exc_badv_we  (exc_badv_we),
        .exc_badv     (exc_badv),
        .ertn         (ertn),
        .hw_int       (hw_int),
        .ipi_int      (ipi_int),
        .era          (era),
        .eentry       (eentry),
        .int_pending  (int_pending)
`ifdef CSR_STABLE_CNT_EN
        ,
        .stable_cnt   (stable_cnt)
`endif
    );

    always #10 clk = ~clk;

    task automatic wr_csr(input logic [13:0] a, input logic [31:0] d, input logic [31:0] m);
        @(negedge clk);
        bus.csr_we    = 1'b1;
        bus.csr_waddr = a;
        bus.csr_wdata = d;
        bus.csr_wmask = m;
        @(negedge clk);
        bus.csr_we    = 1'b0;
    endtask

    task automatic rd_csr(input logic [13:0] a, output logic [31:0] d);
        bus.csr_raddr = a;
        #1;
        d = bus.csr_rdata;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        wr_csr(CSR_CRMD, 32'h7, 32'hFFFF_FFFF);
        wr_csr(CSR_ERA, 32'h55AA, 32'hFFFF_FFFF);
        wr_csr(CSR_TCFG, 32'hB, 32'hFFFF_FFFF);
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        rd_csr(CSR_CRMD, d);
        checks++;
        if (d !== 32'h8) begin failures++; $display("FAIL reset_crmd got=%h want=%h", d, 32'h8); end
        rd_csr(CSR_ESTAT, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_estat got=%h want=0", d); end
        rd_csr(CSR_TVAL, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL reset_tval got=%h want=0", d); end
        rd_csr(CSR_ERA, d);
        checks++;
        if (d !== 32'h0 || era !== 32'h0) begin
            failures++; $display("FAIL reset_era got=%h/%h want=0", d, era);
        end
        checks++;
        if (int_pending !== 1'b0) begin
            failures++; $display("FAIL reset_int_pending got=%b want=0", int_pending);
        end
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_ecfg();
        logic [31:0] d;
        wr_csr(CSR_ECFG, 32'h1FFF, 32'h0A03);
        rd_csr(CSR_ECFG, d);
        checks++;
        if (d !== 32'h0A03) begin failures++; $display("FAIL ecfg_xchg got=%h want=%h", d, 32'h0A03); end
        wr_csr(CSR_ECFG, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_csr(CSR_ECFG, d);
        checks++;
        if (d !== 32'h1BFF) begin failures++; $display("FAIL ecfg_all got=%h want=%h", d, 32'h1BFF); end
        wr_csr(CSR_ECFG, 32'h0, 32'hFFFF_FFFF);
    endtask

    task automatic test_timer();
        logic [31:0] d, e;
        int unsigned exp_tval [10] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 8};
        int cnt;
        // Periodic, InitVal=2
        wr_csr(CSR_TCFG, 32'hB, 32'hFFFF_FFFF);
        for (int i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            rd_csr(CSR_TVAL, d);
            checks++;
            if (d !== exp_tval[i]) begin
                failures++; $display("FAIL timer_seq[%0d] got=%h want=%h", i, d, exp_tval[i]);
            end
            rd_csr(CSR_ESTAT, e);
            checks++;
            if (e[11] !== (i >= 8)) begin
                failures++; $display("FAIL timer_ti[%0d] got=%b want=%b", i, e[11], (i >= 8));
            end
        end
        wr_csr(CSR_TICLR, 32'h1, 32'h1);
        rd_csr(CSR_ESTAT, e);
        checks++;
        if (e[11] !== 1'b0) begin failures++; $display("FAIL ticlr got=%b want=0", e[11]); end
        // TVAL is 6 here; next expiry six cycles later
        cnt = 0;
        e = '0;
        while (cnt < 20 && e[11] !== 1'b1) begin
            @(negedge clk);
            cnt++;
            rd_csr(CSR_ESTAT, e);
        end
        checks++;
        if (cnt != 6 || e[11] !== 1'b1) begin
            failures++; $display("FAIL timer_reexpire cycles=%0d ti=%b want 6/1", cnt, e[11]);
        end
        // Disable on the cycle after a reload: TVAL freezes at 7
        wr_csr(CSR_TCFG, 32'hB, 32'hFFFF_FFFF);
        wr_csr(CSR_TCFG, 32'h8, 32'hFFFF_FFFF);
        repeat (3) @(negedge clk);
        rd_csr(CSR_TVAL, d);
        checks++;
        if (d !== 32'h7) begin failures++; $display("FAIL timer_freeze got=%h want=7", d); end
        // One-shot holds at 0
        wr_csr(CSR_TICLR, 32'h1, 32'h1);
        wr_csr(CSR_TCFG, 32'h9, 32'hFFFF_FFFF);
        repeat (11) @(negedge clk);
        rd_csr(CSR_TVAL, d);
        rd_csr(CSR_ESTAT, e);
        checks++;
        if (d !== 32'h0 || e[11] !== 1'b1) begin
            failures++; $display("FAIL timer_oneshot tval=%h ti=%b want 0/1", d, e[11]);
        end
        wr_csr(CSR_TICLR, 32'h1, 32'h1);
        repeat (3) @(negedge clk);
        rd_csr(CSR_ESTAT, e);
        checks++;
        if (e[11] !== 1'b0) begin failures++; $display("FAIL timer_oneshot_rearm ti=%b want 0", e[11]); end
        // InitVal=0 periodic never fires
        wr_csr(CSR_TCFG, 32'h3, 32'hFFFF_FFFF);
        repeat (4) @(negedge clk);
        rd_csr(CSR_TVAL, d);
        rd_csr(CSR_ESTAT, e);
        checks++;
        if (d !== 32'h0 || e[11] !== 1'b0) begin
            failures++; $display("FAIL timer_init0 tval=%h ti=%b want 0/0", d, e[11]);
        end
        wr_csr(CSR_TCFG, 32'h0, 32'hFFFF_FFFF);
    endtask

    task automatic test_interrupts();
        logic [31:0] d;
        wr_csr(CSR_ECFG, 32'h4, 32'hFFFF_FFFF);
        wr_csr(CSR_CRMD, 32'h4, 32'h4);
        rd_csr(CSR_CRMD, d);
        checks++;
        if (d !== 32'hC) begin failures++; $display("FAIL crmd_ie got=%h want=%h", d, 32'hC); end
        hw_int = 8'h01;
        @(negedge clk);
        checks++;
        if (int_pending !== 1'b0) begin failures++; $display("FAIL hwi_rise1 got=%b want=0", int_pending); end
        @(negedge clk);
        checks++;
        if (int_pending !== 1'b1) begin failures++; $display("FAIL hwi_rise2 got=%b want=1", int_pending); end
        rd_csr(CSR_ESTAT, d);
        checks++;
        if (d !== 32'h4) begin failures++; $display("FAIL hwi_estat got=%h want=4", d); end
        hw_int = 8'h00;
        @(negedge clk);
        checks++;
        if (int_pending !== 1'b1) begin failures++; $display("FAIL hwi_fall1 got=%b want=1", int_pending); end
        @(negedge clk);
        checks++;
        if (int_pending !== 1'b0) begin failures++; $display("FAIL hwi_fall2 got=%b want=0", int_pending); end
        // IPI enabled, a masked hardware line alongside
        wr_csr(CSR_ECFG, 32'h1000, 32'hFFFF_FFFF);
        hw_int = 8'h02;
        repeat (2) @(negedge clk);
        checks++;
        if (int_pending !== 1'b0) begin failures++; $display("FAIL hwi_masked got=%b want=0", int_pending); end
        ipi_int = 1'b1;
        repeat (2) @(negedge clk);
        rd_csr(CSR_ESTAT, d);
        checks++;
        if (int_pending !== 1'b1 || d !== 32'h1008) begin
            failures++; $display("FAIL ipi pend=%b estat=%h want 1/%h", int_pending, d, 32'h1008);
        end
        ipi_int = 1'b0;
        hw_int  = 8'h00;
        repeat (2) @(negedge clk);
        checks++;
        if (int_pending !== 1'b0) begin failures++; $display("FAIL ipi_fall got=%b want=0", int_pending); end
    endtask

    task automatic test_exception();
        logic [31:0] d;
        wr_csr(CSR_CRMD, 32'h7, 32'hFFFF_FFFF);
        @(negedge clk);
        exc_valid = 1'b1; exc_pc = 32'h1C00_0100; exc_ecode = ECODE_SYS;
        exc_esubcode = 9'h0; exc_badv_we = 1'b1; exc_badv = 32'hDEAD_BEEF;
        @(negedge clk);
        exc_valid = 1'b0; exc_badv_we = 1'b0;
        rd_csr(CSR_CRMD, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL exc_crmd got=%h want=0", d); end
        rd_csr(CSR_PRMD, d);
        checks++;
        if (d !== 32'h7) begin failures++; $display("FAIL exc_prmd got=%h want=7", d); end
        checks++;
        if (era !== 32'h1C00_0100) begin failures++; $display("FAIL exc_era got=%h want=%h", era, 32'h1C00_0100); end
        rd_csr(CSR_ESTAT, d);
        checks++;
        if (d !== 32'h000B_0000) begin failures++; $display("FAIL exc_estat got=%h want=%h", d, 32'h000B_0000); end
        rd_csr(CSR_BADV, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL exc_badv got=%h want=%h", d, 32'hDEAD_BEEF); end
        @(negedge clk);
        ertn = 1'b1;
        @(negedge clk);
        ertn = 1'b0;
        rd_csr(CSR_CRMD, d);
        checks++;
        if (d !== 32'h7) begin failures++; $display("FAIL ertn_crmd got=%h want=7", d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        // Exception and CRMD write in the same cycle
        @(negedge clk);
        exc_valid = 1'b1; exc_pc = 32'h1C00_0200; exc_ecode = ECODE_BRK; exc_esubcode = 9'h1;
        bus.csr_we = 1'b1; bus.csr_waddr = CSR_CRMD; bus.csr_wdata = 32'h3; bus.csr_wmask = '1;
        @(negedge clk);
        exc_valid = 1'b0; bus.csr_we = 1'b0;
        rd_csr(CSR_CRMD, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL prio_crmd got=%h want=0", d); end
        rd_csr(CSR_PRMD, d);
        checks++;
        if (d !== 32'h7) begin failures++; $display("FAIL prio_prmd got=%h want=7", d); end
        rd_csr(CSR_ESTAT, d);
        checks++;
        if (d !== 32'h004C_0000) begin failures++; $display("FAIL prio_estat got=%h want=%h", d, 32'h004C_0000); end
        // Exception without BADV qualifier: a same-cycle BADV write commits
        @(negedge clk);
        exc_valid = 1'b1; exc_pc = 32'h1C00_0300; exc_ecode = ECODE_ALE; exc_esubcode = 9'h0;
        bus.csr_we = 1'b1; bus.csr_waddr = CSR_BADV; bus.csr_wdata = 32'h1234_5678;
        @(negedge clk);
        exc_valid = 1'b0; bus.csr_we = 1'b0;
        rd_csr(CSR_BADV, d);
        checks++;
        if (d !== 32'h1234_5678 || era !== 32'h1C00_0300) begin
            failures++; $display("FAIL prio_badv badv=%h era=%h want %h/%h", d, era, 32'h1234_5678, 32'h1C00_0300);
        end
        // ERTN overrides PLV/IE, other CRMD bits from the write commit
        wr_csr(CSR_PRMD, 32'h5, 32'hFFFF_FFFF);
        @(negedge clk);
        ertn = 1'b1;
        bus.csr_we = 1'b1; bus.csr_waddr = CSR_CRMD; bus.csr_wdata = 32'h13;
        @(negedge clk);
        ertn = 1'b0; bus.csr_we = 1'b0;
        rd_csr(CSR_CRMD, d);
        checks++;
        if (d !== 32'h15) begin failures++; $display("FAIL prio_ertn got=%h want=%h", d, 32'h15); end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        for (int i = 0; i < 4; i++) begin
            wr_csr(CSR_SAVE + 14'(i), 32'hA500_0000 + 32'(i * 17), 32'hFFFF_FFFF);
        end
        for (int i = 0; i < 4; i++) begin
            rd_csr(CSR_SAVE + 14'(i), d);
            checks++;
            if (d !== 32'hA500_0000 + 32'(i * 17)) begin
                failures++; $display("FAIL save[%0d] got=%h want=%h", i, d, 32'hA500_0000 + 32'(i * 17));
            end
        end
        wr_csr(CSR_SAVE + 14'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_csr(CSR_SAVE + 14'd4, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL save_oob got=%h want=0", d); end
        rd_csr(14'h002, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL unimpl got=%h want=0", d); end
        wr_csr(CSR_EENTRY, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        rd_csr(CSR_EENTRY, d);
        checks++;
        if (d !== 32'hFFFF_FFC0 || eentry !== 32'hFFFF_FFC0) begin
            failures++; $display("FAIL eentry got=%h/%h want=%h", d, eentry, 32'hFFFF_FFC0);
        end
        wr_csr(CSR_TID, 32'hCAFE_F00D, 32'hFFFF_0000);
        rd_csr(CSR_TID, d);
        checks++;
        if (d !== 32'hCAFE_0000) begin failures++; $display("FAIL tid got=%h want=%h", d, 32'hCAFE_0000); end
        rd_csr(CSR_TICLR, d);
        checks++;
        if (d !== 32'h0) begin failures++; $display("FAIL ticlr_read got=%h want=0", d); end
    endtask

`ifdef CSR_STABLE_CNT_EN
    task automatic test_stable_cnt();
        logic [63:0] c0;
        @(negedge clk);
        c0 = stable_cnt;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++;
            if (stable_cnt !== c0 + 64'(i)) begin
                failures++; $display("FAIL stable_cnt got=%h want=%h", stable_cnt, c0 + 64'(i));
            end
        end
    endtask
`endif

    initial begin
        resetn = 1'b0;
        exc_valid = 1'b0; exc_badv_we = 1'b0; ertn = 1'b0; ipi_int = 1'b0;
        exc_ecode = '0; exc_esubcode = '0; exc_pc = '0; exc_badv = '0; hw_int = '0;
        bus.csr_raddr = '0; bus.csr_we = 1'b0; bus.csr_waddr = '0;
        bus.csr_wdata = '0; bus.csr_wmask = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        test_reset();
        test_ecfg();
        test_timer();
        test_interrupts();
        test_exception();
        test_back_to_back();
        test_regs();
`ifdef CSR_STABLE_CNT_EN
        test_stable_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
